// File: rtl/up_dn_cmd_conditioner_pkg.sv
// up_dn_pkg: constants shared between the command conditioner and the
// up/down counter it drives.
//   UP_DN_CNT_W : default counter / load-value width
//   cmd_e       : command codes in ascending priority (NONE < UP < DOWN < LOAD)
package up_dn_pkg;

  localparam int unsigned UP_DN_CNT_W = 5;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_UP   = 2'd1,
    CMD_DOWN = 2'd2,
    CMD_LOAD = 2'd3
  } cmd_e;

endpackage

// File: rtl/up_dn_cmd_conditioner_if.sv
// up_dn_cmd_conditioner_if: raw button/switch inputs and conditioned
// command outputs of the up/down counter front end.
//   Btn_Up/Btn_Down/Btn_Load : raw async buttons, active-high
//   Sw_In                    : raw async load-value switches
//   Up/Down/Load             : one-cycle command pulses
//   IN                       : registered load value
// modport master : the button/switch source (drives raw inputs)
// modport slave  : the conditioner (drives commands)
interface up_dn_cmd_conditioner_if #(
  parameter int unsigned CNT_W = up_dn_pkg::UP_DN_CNT_W
);
  logic             Btn_Up;
  logic             Btn_Down;
  logic             Btn_Load;
  logic [CNT_W-1:0] Sw_In;
  logic             Up;
  logic             Down;
  logic             Load;
  logic [CNT_W-1:0] IN;

  modport master (
    output Btn_Up, Btn_Down, Btn_Load, Sw_In,
    input  Up, Down, Load, IN
  );

  modport slave (
    input  Btn_Up, Btn_Down, Btn_Load, Sw_In,
    output Up, Down, Load, IN
  );
endinterface

// File: rtl/up_dn_cmd_conditioner_btn_debounce.sv
// btn_debounce: synchroniser, debouncer and rising-edge detector for one
// async button.
//   clk_i, rst_i : clock, async active-high reset
//   btn_i        : raw async button
//   stable_o     : debounced level
//   rise_o       : one-cycle pulse, registered together with a 0->1 stable change
module btn_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic stable_o,
  output logic rise_o
);
  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;

  assign synced = sync_q[SYNC_STAGES-1];

  // The edge on which the count would reach DEBOUNCE_CYCLES is the accepting
  // edge, so stable and the rise flag update together there.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    if (synced != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = synced;
        rise_d   = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
endmodule

// File: rtl/up_dn_cmd_conditioner.sv
// up_dn_cmd_conditioner: turns raw buttons/switches into single-cycle
// Up/Down/Load commands for the up/down counter.
//   CLK : clock
//   RST : async active-high reset
//   cmd : up_dn_cmd_conditioner_if.slave (raw inputs in, commands out)
// Priority Load > Down > Up; losing requests are dropped. IN is loaded from
// the synchronised switches on the edge that raises Load.
// Optional macro UP_DN_CMD_AUTO_REPEAT_EN: held Up/Down re-pulses every
// REPEAT_CYCLES cycles after a won initial pulse.
module up_dn_cmd_conditioner
  import up_dn_pkg::*;
#(
  parameter int unsigned CNT_W           = UP_DN_CNT_W,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_CYCLES   = 8
) (
  input logic                   CLK,
  input logic                   RST,
  up_dn_cmd_conditioner_if.slave cmd
);
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("up_dn_cmd_conditioner: SYNC_STAGES, DEBOUNCE_CYCLES, REPEAT_CYCLES must be >= 2");
  end

  logic rise_up, rise_dn, rise_ld;
  logic stable_up, stable_dn, stable_ld;
  logic req_up, req_dn, req_ld;
  cmd_e cmd_sel;

  logic             up_q, dn_q, ld_q;
  logic [CNT_W-1:0] in_q, in_d;
  logic [CNT_W-1:0] sw_sync_q [SYNC_STAGES];

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk_i(CLK), .rst_i(RST), .btn_i(cmd.Btn_Up), .stable_o(stable_up), .rise_o(rise_up)
  );
  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk_i(CLK), .rst_i(RST), .btn_i(cmd.Btn_Down), .stable_o(stable_dn), .rise_o(rise_dn)
  );
  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ld (
    .clk_i(CLK), .rst_i(RST), .btn_i(cmd.Btn_Load), .stable_o(stable_ld), .rise_o(rise_ld)
  );

  assign req_ld = rise_ld;

`ifdef UP_DN_CMD_AUTO_REPEAT_EN
  localparam int unsigned   RW       = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

  logic          up_act_q, dn_act_q;
  logic [RW-1:0] up_rcnt_q, dn_rcnt_q;
  logic          unused_stable;

  assign unused_stable = stable_ld;

  // A channel arms only once it has actually been pulsed; the stable term
  // suppresses a repeat landing in the cycle the release is accepted.
  assign req_up = rise_up | (stable_up & up_act_q & (up_rcnt_q == RPT_LAST));
  assign req_dn = rise_dn | (stable_dn & dn_act_q & (dn_rcnt_q == RPT_LAST));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      up_act_q  <= 1'b0;
      up_rcnt_q <= '0;
      dn_act_q  <= 1'b0;
      dn_rcnt_q <= '0;
    end else begin
      if (!stable_up) begin
        up_act_q  <= 1'b0;
        up_rcnt_q <= '0;
      end else if (cmd_sel == CMD_UP) begin
        up_act_q  <= 1'b1;
        up_rcnt_q <= '0;
      end else if (up_act_q) begin
        up_rcnt_q <= (up_rcnt_q == RPT_LAST) ? '0 : up_rcnt_q + 1'b1;
      end

      if (!stable_dn) begin
        dn_act_q  <= 1'b0;
        dn_rcnt_q <= '0;
      end else if (cmd_sel == CMD_DOWN) begin
        dn_act_q  <= 1'b1;
        dn_rcnt_q <= '0;
      end else if (dn_act_q) begin
        dn_rcnt_q <= (dn_rcnt_q == RPT_LAST) ? '0 : dn_rcnt_q + 1'b1;
      end
    end
  end
`else
  logic unused_stable;

  assign unused_stable = stable_up ^ stable_dn ^ stable_ld;
  assign req_up        = rise_up;
  assign req_dn        = rise_dn;
`endif

  always_comb begin
    cmd_sel = CMD_NONE;
    if (req_ld)      cmd_sel = CMD_LOAD;
    else if (req_dn) cmd_sel = CMD_DOWN;
    else if (req_up) cmd_sel = CMD_UP;
  end

  always_comb begin
    in_d = in_q;
    if (cmd_sel == CMD_LOAD) in_d = sw_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= '0;
      up_q <= 1'b0;
      dn_q <= 1'b0;
      ld_q <= 1'b0;
      in_q <= '0;
    end else begin
      sw_sync_q[0] <= cmd.Sw_In;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_q[i-1];
      up_q <= (cmd_sel == CMD_UP);
      dn_q <= (cmd_sel == CMD_DOWN);
      ld_q <= (cmd_sel == CMD_LOAD);
      in_q <= in_d;
    end
  end

  assign cmd.Up   = up_q;
  assign cmd.Down = dn_q;
  assign cmd.Load = ld_q;
  assign cmd.IN   = in_q;
endmodule

// File: tb/tb_up_dn_cmd_conditioner.sv
// Directed bench for up_dn_cmd_conditioner with default parameters.
// Cycle numbers count negedges after a stimulus change; cycle n observes the
// state after the n-th rising edge that sampled the new input.
module tb_up_dn_cmd_conditioner;
`ifdef UP_DN_CMD_AUTO_REPEAT_EN
  localparam int EXP_A = 5, EXP_B = 3, EXP_E = 3, EXP_G = 6, EXP_G_LAST = 59;
`else
  localparam int EXP_A = 1, EXP_B = 1, EXP_E = 1, EXP_G = 1, EXP_G_LAST = 19;
`endif

  logic CLK;
  logic RST;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_up, n_dn, n_ld, n_multi, cyc_no, up_at;

  up_dn_cmd_conditioner_if #(.CNT_W(5)) ifc ();

  up_dn_cmd_conditioner #(
    .CNT_W(5), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .REPEAT_CYCLES(8)
  ) dut (
    .CLK(CLK), .RST(RST), .cmd(ifc)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_up = 0; n_dn = 0; n_ld = 0; cyc_no = 0; up_at = -1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      cyc_no++;
      if (ifc.Up === 1'b1) begin n_up++; up_at = cyc_no; end
      if (ifc.Down === 1'b1) n_dn++;
      if (ifc.Load === 1'b1) n_ld++;
      if ((int'(ifc.Up) + int'(ifc.Down) + int'(ifc.Load)) > 1) n_multi++;
    end
  endtask

  initial begin
    n_multi = 0;
    clr();
    RST = 1'b1;
    ifc.Btn_Up = 1'b0; ifc.Btn_Down = 1'b0; ifc.Btn_Load = 1'b0; ifc.Sw_In = '0;

    // reset state
    run(2);
    chk("rst_up", ifc.Up, 0);
    chk("rst_down", ifc.Down, 0);
    chk("rst_load", ifc.Load, 0);
    chk("rst_in", ifc.IN, 0);
    RST = 1'b0;
    run(3);

    // clean Up press, 40 cycles
    clr(); ifc.Btn_Up = 1'b1;
    run(18); chk("up_early", n_up, 0);
    run(1);  chk("up_edge19", ifc.Up, 1); chk("up_at", up_at, 19);
    run(21); ifc.Btn_Up = 1'b0;
    run(30);
    chk("up_count", n_up, EXP_A);
    chk("up_no_down", n_dn, 0);
    chk("up_no_load", n_ld, 0);

    // bouncing Down, then held
    clr();
    for (int i = 0; i < 6; i++) begin
      ifc.Btn_Down = (i % 2 == 0);
      run(5);
    end
    chk("dn_bounce", n_dn, 0);
    clr(); ifc.Btn_Down = 1'b1;
    run(18); chk("dn_early", n_dn, 0);
    run(1);  chk("dn_edge19", ifc.Down, 1);
    run(1);  chk("dn_single", ifc.Down, 0);
    ifc.Btn_Down = 1'b0;
    run(30); chk("dn_count", n_dn, EXP_B);

    // Load captures switches
    ifc.Sw_In = 5'd21; run(4);
    clr(); ifc.Btn_Load = 1'b1;
    run(18); chk("ld_early", ifc.Load, 0); chk("in_pre", ifc.IN, 0);
    run(1);  chk("ld_edge19", ifc.Load, 1); chk("in_21", ifc.IN, 21);
    ifc.Btn_Load = 1'b0; ifc.Sw_In = 5'd3;
    run(1);  chk("ld_single", ifc.Load, 0);
    run(30); chk("in_hold", ifc.IN, 21); chk("ld_count", n_ld, 1);

    // Up and Load together: Load wins
    clr(); ifc.Btn_Up = 1'b1; ifc.Btn_Load = 1'b1;
    run(19); chk("pri_ld", ifc.Load, 1); chk("pri_ld_up", ifc.Up, 0); chk("in_3", ifc.IN, 3);
    ifc.Btn_Up = 1'b0; ifc.Btn_Load = 1'b0;
    run(30); chk("ld_up_dropped", n_up, 0); chk("ld_once", n_ld, 1);
    clr(); ifc.Btn_Up = 1'b1;
    run(19); chk("up_repress1", ifc.Up, 1);
    ifc.Btn_Up = 1'b0; run(30);

    // Up and Down together: Down wins
    clr(); ifc.Btn_Up = 1'b1; ifc.Btn_Down = 1'b1;
    run(19); chk("pri_dn", ifc.Down, 1); chk("pri_dn_up", ifc.Up, 0);
    ifc.Btn_Up = 1'b0; ifc.Btn_Down = 1'b0;
    run(30); chk("dn_up_dropped", n_up, 0); chk("dn_win_count", n_dn, EXP_E);
    clr(); ifc.Btn_Up = 1'b1;
    run(19); chk("up_repress2", ifc.Up, 1);
    ifc.Btn_Up = 1'b0; run(30);

    // reset mid-debounce (count 10), button held through reset
    ifc.Btn_Down = 1'b1;
    run(12);
    RST = 1'b1; #1;
    chk("mid_rst_in", ifc.IN, 0);
    chk("mid_rst_down", ifc.Down, 0);
    chk("mid_rst_up", ifc.Up, 0);
    chk("mid_rst_load", ifc.Load, 0);
    run(3);
    RST = 1'b0;
    clr();
    run(18); chk("post_rst_early", n_dn, 0);
    run(1);  chk("post_rst_dn", ifc.Down, 1);
    ifc.Btn_Down = 1'b0; run(30);

    // long Up hold: repeat behaviour
    clr(); ifc.Btn_Up = 1'b1;
    run(59);
    chk("hold_count", n_up, EXP_G);
    chk("hold_last", up_at, EXP_G_LAST);
    ifc.Btn_Up = 1'b0; run(30);

    chk("onehot", n_multi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
